// File: rtl/odd_reg_fetch.sv
// Register-fetch / forwarding stage for the odd pipe, one cycle from accepted input to outputs.
// Owns the 128 x 128-bit RegTable and bypasses same-cycle writebacks into operand reads.
// A shift-register scoreboard raises a combinational stall while a source register is in flight.
// Ports: clk/reset (synchronous, active-low); decoded instruction in (in_valid, op_in, format_in,
//   ra/rb/rc_addr with use_* flags, rt_addr_in, imm_in, reg_write_in); even/odd writeback ports;
//   stall back to the decoder; registered op/format/rt_addr/ra/rb/rt_st/imm/reg_write to local store.
module odd_reg_fetch #(
  parameter int LS_LAT = 7,
  parameter int NREGS  = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [0:10]  op_in,
  input  logic [2:0]   format_in,
  input  logic [0:6]   ra_addr,
  input  logic [0:6]   rb_addr,
  input  logic [0:6]   rc_addr,
  input  logic         use_ra,
  input  logic         use_rb,
  input  logic         use_rc,
  input  logic [0:6]   rt_addr_in,
  input  logic [0:17]  imm_in,
  input  logic         reg_write_in,
  input  logic [127:0] wb_even_data,
  input  logic [6:0]   wb_even_addr,
  input  logic         wb_even_we,
  input  logic [127:0] wb_odd_data,
  input  logic [6:0]   wb_odd_addr,
  input  logic         wb_odd_we,
  output logic         stall,
  output logic [0:10]  op,
  output logic [2:0]   format,
  output logic [0:6]   rt_addr,
  output logic [0:127] ra,
  output logic [0:127] rb,
  output logic [0:127] rt_st,
  output logic [0:17]  imm,
  output logic         reg_write
);

  // One scoreboard slot per local-store stage; the entry shifting out of the
  // last slot lines up with its wb_odd presentation, so the bypass takes over.
  localparam int SB_N = LS_LAT - 1;

  logic [127:0] regs [NREGS];
  logic [SB_N-1:0] sb_v;
  logic [6:0]      sb_a [SB_N];

  logic [127:0] ra_byp, rb_byp, rc_byp;
  logic         hazard, issue, is_nop, sb_ins;

  // Odd writeback beats even writeback, which beats the array.
  function automatic logic [127:0] read_opnd(input logic [6:0] a, input logic use_it);
    if (!use_it)
      return '0;
    if (wb_odd_we && (wb_odd_addr == a))
      return wb_odd_data;
    if (wb_even_we && (wb_even_addr == a))
      return wb_even_data;
    return regs[a];
  endfunction

  assign ra_byp = read_opnd(ra_addr, use_ra);
  assign rb_byp = read_opnd(rb_addr, use_rb);
  assign rc_byp = read_opnd(rc_addr, use_rc);

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_N; i++) begin
      if (sb_v[i] && ((use_ra && (ra_addr == sb_a[i])) ||
                      (use_rb && (rb_addr == sb_a[i])) ||
                      (use_rc && (rc_addr == sb_a[i]))))
        hazard = 1'b1;
    end
  end

  assign stall  = in_valid & hazard;
  assign issue  = in_valid & ~hazard;
  assign is_nop = (format_in == 3'd0) && (op_in == 11'd0);
  // Only odd-pipe results that actually write the RegTable need tracking.
  assign sb_ins = issue & reg_write_in & ~is_nop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      op        <= '0;
      format    <= '0;
      rt_addr   <= '0;
      ra        <= '0;
      rb        <= '0;
      rt_st     <= '0;
      imm       <= '0;
      reg_write <= 1'b0;
      sb_v      <= '0;
      for (int i = 0; i < SB_N; i++)
        sb_a[i] <= '0;
      for (int r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else begin
      // Odd write is issued last so it wins on an address collision.
      if (wb_even_we)
        regs[wb_even_addr] <= wb_even_data;
      if (wb_odd_we)
        regs[wb_odd_addr] <= wb_odd_data;

      sb_v    <= {sb_v[SB_N-2:0], sb_ins};
      sb_a[0] <= rt_addr_in;
      for (int i = 1; i < SB_N; i++)
        sb_a[i] <= sb_a[i-1];

      if (issue) begin
        op        <= op_in;
        format    <= format_in;
        rt_addr   <= rt_addr_in;
        ra        <= ra_byp;
        rb        <= rb_byp;
        rt_st     <= rc_byp;
        imm       <= imm_in;
        reg_write <= reg_write_in & ~is_nop;
      end else begin
        op        <= '0;
        format    <= '0;
        rt_addr   <= '0;
        ra        <= '0;
        rb        <= '0;
        rt_st     <= '0;
        imm       <= '0;
        reg_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_odd_reg_fetch.sv
module tb_odd_reg_fetch;

  typedef struct packed {
    logic [10:0]  op;
    logic [2:0]   fmt;
    logic [6:0]   rt;
    logic [127:0] ra;
    logic [127:0] rb;
    logic [127:0] rtst;
    logic [17:0]  imm;
    logic         rw;
  } out_t;

  localparam logic [10:0] OP_LQX  = 11'h1C4;
  localparam logic [10:0] OP_STQX = 11'h144;
  localparam logic [10:0] OP_A    = 11'h0C0;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [10:0]  op_in;
  logic [2:0]   format_in;
  logic [6:0]   ra_addr, rb_addr, rc_addr;
  logic         use_ra, use_rb, use_rc;
  logic [6:0]   rt_addr_in;
  logic [17:0]  imm_in;
  logic         reg_write_in;
  logic [127:0] wb_even_data, wb_odd_data;
  logic [6:0]   wb_even_addr, wb_odd_addr;
  logic         wb_even_we, wb_odd_we;
  logic         stall;
  logic [10:0]  op;
  logic [2:0]   format;
  logic [6:0]   rt_addr;
  logic [127:0] ra, rb, rt_st;
  logic [17:0]  imm;
  logic         reg_write;

  out_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  odd_reg_fetch #(.LS_LAT(7), .NREGS(128)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op_in(op_in), .format_in(format_in),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
    .use_ra(use_ra), .use_rb(use_rb), .use_rc(use_rc),
    .rt_addr_in(rt_addr_in), .imm_in(imm_in), .reg_write_in(reg_write_in),
    .wb_even_data(wb_even_data), .wb_even_addr(wb_even_addr), .wb_even_we(wb_even_we),
    .wb_odd_data(wb_odd_data), .wb_odd_addr(wb_odd_addr), .wb_odd_we(wb_odd_we),
    .stall(stall), .op(op), .format(format), .rt_addr(rt_addr),
    .ra(ra), .rb(rb), .rt_st(rt_st), .imm(imm), .reg_write(reg_write)
  );

  // Scoreboard consumer: each pushed entry describes the output registered at the next edge.
  always @(posedge clk) begin
    out_t e;
    out_t act;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {op, format, rt_addr, ra, rb, rt_st, imm, reg_write};
      n_vec++;
      if (act !== e) begin
        n_err++;
        $display("FAIL out_reg: got %h expected %h", act, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic clr_in();
    in_valid = 0; op_in = '0; format_in = '0;
    ra_addr = '0; rb_addr = '0; rc_addr = '0;
    use_ra = 0; use_rb = 0; use_rc = 0;
    rt_addr_in = '0; imm_in = '0; reg_write_in = 0;
    wb_even_data = '0; wb_even_addr = '0; wb_even_we = 0;
    wb_odd_data = '0; wb_odd_addr = '0; wb_odd_we = 0;
  endtask

  task automatic set_instr(input logic [10:0] o, input logic [2:0] f, input logic [6:0] rt,
                           input logic [6:0] a, input logic ua, input logic [6:0] b, input logic ub,
                           input logic [6:0] c, input logic uc, input logic [17:0] im, input logic w);
    in_valid = 1; op_in = o; format_in = f; rt_addr_in = rt;
    ra_addr = a; use_ra = ua; rb_addr = b; use_rb = ub; rc_addr = c; use_rc = uc;
    imm_in = im; reg_write_in = w;
  endtask

  task automatic push_exp(input logic [10:0] o, input logic [2:0] f, input logic [6:0] rt,
                          input logic [127:0] a, input logic [127:0] b, input logic [127:0] c,
                          input logic [17:0] im, input logic w);
    out_t e;
    e.op = o; e.fmt = f; e.rt = rt; e.ra = a; e.rb = b; e.rtst = c; e.imm = im; e.rw = w;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 0;
    clr_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    #1;
    n_vec++;
    if ({op, format, rt_addr, ra, rb, rt_st, imm, reg_write} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: op=%h fmt=%h rt=%h rw=%b expected all zero", op, format, rt_addr, reg_write);
    end
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_stall: stall=%b expected 0", stall);
    end
    set_instr(OP_STQX, 3'd1, 7'd20, 7'd5, 1, 7'd0, 0, 7'd0, 0, 18'h5, 0);
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset_read_stall: stall=%b expected 0", stall);
    end
    push_exp(OP_STQX, 3'd1, 7'd20, '0, '0, '0, 18'h5, 0);
    @(negedge clk);
    clr_in();
    push_exp('0, '0, '0, '0, '0, '0, '0, 0);
  endtask

  task automatic test_even_bypass();
    logic [127:0] d;
    d = {8{16'hAAAA}};
    @(negedge clk);
    clr_in();
    wb_even_we = 1; wb_even_addr = 7'd3; wb_even_data = d;
    set_instr(OP_A, 3'd2, 7'd40, 7'd3, 1, 7'd0, 0, 7'd0, 0, 18'h30F0F, 0);
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL even_bypass_stall: stall=%b expected 0", stall);
    end
    push_exp(OP_A, 3'd2, 7'd40, d, '0, '0, 18'h30F0F, 0);
    @(negedge clk);
    clr_in();
    push_exp('0, '0, '0, '0, '0, '0, '0, 0);
    @(negedge clk);
    // rc_addr points at r3 but is unused, so rt_st must stay zero.
    set_instr(OP_A, 3'd2, 7'd41, 7'd3, 1, 7'd3, 1, 7'd3, 0, 18'h1, 0);
    push_exp(OP_A, 3'd2, 7'd41, d, d, '0, 18'h1, 0);
    @(negedge clk);
    clr_in();
  endtask

  task automatic test_both_wb();
    logic [127:0] de, dodd;
    de = {16{8'h11}};
    dodd = {16{8'h22}};
    @(negedge clk);
    wb_even_we = 1; wb_even_addr = 7'd9; wb_even_data = de;
    wb_odd_we = 1; wb_odd_addr = 7'd9; wb_odd_data = dodd;
    set_instr(OP_A, 3'd3, 7'd42, 7'd9, 1, 7'd9, 1, 7'd9, 1, 18'h2, 0);
    push_exp(OP_A, 3'd3, 7'd42, dodd, dodd, dodd, 18'h2, 0);
    @(negedge clk);
    clr_in();
    @(negedge clk);
    set_instr(OP_A, 3'd3, 7'd43, 7'd9, 1, 7'd9, 1, 7'd9, 1, 18'h3, 0);
    push_exp(OP_A, 3'd3, 7'd43, dodd, dodd, dodd, 18'h3, 0);
    @(negedge clk);
    clr_in();
  endtask

  task automatic test_load_use();
    logic [127:0] d;
    d = {4{32'hDEADBEEF}};
    @(negedge clk);
    set_instr(OP_LQX, 3'd1, 7'd10, 7'd1, 1, 7'd2, 1, 7'd0, 0, 18'h0, 1);
    push_exp(OP_LQX, 3'd1, 7'd10, '0, '0, '0, 18'h0, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      set_instr(OP_STQX, 3'd1, 7'd10, 7'd0, 0, 7'd0, 0, 7'd10, 1, 18'h7, 0);
      #1;
      n_vec++;
      if (stall !== 1'b1) begin
        n_err++;
        $display("FAIL load_use_stall_%0d: stall=%b expected 1", k, stall);
      end
      push_exp('0, '0, '0, '0, '0, '0, '0, 0);
    end
    @(negedge clk);
    wb_odd_we = 1; wb_odd_addr = 7'd10; wb_odd_data = d;
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL load_use_release: stall=%b expected 0", stall);
    end
    push_exp(OP_STQX, 3'd1, 7'd10, '0, '0, d, 18'h7, 0);
    @(negedge clk);
    clr_in();
  endtask

  task automatic test_store_and_nop();
    @(negedge clk);
    set_instr(OP_STQX, 3'd1, 7'd4, 7'd0, 0, 7'd0, 0, 7'd0, 0, 18'h11, 0);
    push_exp(OP_STQX, 3'd1, 7'd4, '0, '0, '0, 18'h11, 0);
    @(negedge clk);
    set_instr(OP_A, 3'd1, 7'd5, 7'd4, 1, 7'd0, 0, 7'd0, 0, 18'h12, 0);
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL store_no_hazard: stall=%b expected 0", stall);
    end
    push_exp(OP_A, 3'd1, 7'd5, '0, '0, '0, 18'h12, 0);
    @(negedge clk);
    set_instr('0, 3'd0, 7'd6, 7'd0, 0, 7'd0, 0, 7'd0, 0, 18'h0, 1);
    push_exp('0, 3'd0, 7'd6, '0, '0, '0, 18'h0, 0);
    @(negedge clk);
    set_instr(OP_A, 3'd1, 7'd7, 7'd6, 1, 7'd6, 1, 7'd6, 1, 18'h13, 0);
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL nop_no_entry: stall=%b expected 0", stall);
    end
    push_exp(OP_A, 3'd1, 7'd7, '0, '0, '0, 18'h13, 0);
    @(negedge clk);
    clr_in();
  endtask

  // Two loads to r20 one cycle apart: the reader waits on the younger one.
  task automatic test_back_to_back();
    logic [127:0] d1, d2;
    d1 = {4{32'h01234567}};
    d2 = {4{32'h89ABCDEF}};
    @(negedge clk);
    set_instr(OP_LQX, 3'd1, 7'd20, 7'd0, 0, 7'd0, 0, 7'd0, 0, 18'h21, 1);
    push_exp(OP_LQX, 3'd1, 7'd20, '0, '0, '0, 18'h21, 1);
    @(negedge clk);
    set_instr(OP_LQX, 3'd1, 7'd20, 7'd0, 0, 7'd0, 0, 7'd0, 0, 18'h22, 1);
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second_load: stall=%b expected 0", stall);
    end
    push_exp(OP_LQX, 3'd1, 7'd20, '0, '0, '0, 18'h22, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      set_instr(OP_STQX, 3'd1, 7'd30, 7'd0, 0, 7'd0, 0, 7'd20, 1, 18'h23, 0);
      if (k == 5) begin
        wb_odd_we = 1; wb_odd_addr = 7'd20; wb_odd_data = d1;
      end
      #1;
      n_vec++;
      if (stall !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_stall_%0d: stall=%b expected 1", k, stall);
      end
      push_exp('0, '0, '0, '0, '0, '0, '0, 0);
    end
    @(negedge clk);
    wb_odd_we = 1; wb_odd_addr = 7'd20; wb_odd_data = d2;
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_release: stall=%b expected 0", stall);
    end
    push_exp(OP_STQX, 3'd1, 7'd30, '0, '0, d2, 18'h23, 0);
    @(negedge clk);
    clr_in();
  endtask

  task automatic test_reset_flush();
    @(negedge clk);
    set_instr(OP_LQX, 3'd1, 7'd12, 7'd0, 0, 7'd0, 0, 7'd0, 0, 18'h31, 1);
    push_exp(OP_LQX, 3'd1, 7'd12, '0, '0, '0, 18'h31, 1);
    @(negedge clk);
    clr_in();
    wb_even_we = 1; wb_even_addr = 7'd50; wb_even_data = {32{4'h5}};
    reset = 0;
    @(negedge clk);
    n_vec++;
    if ({op, format, rt_addr, reg_write} !== '0) begin
      n_err++;
      $display("FAIL flush_outputs: op=%h fmt=%h rt=%h rw=%b expected zero", op, format, rt_addr, reg_write);
    end
    reset = 1;
    clr_in();
    // r10 held load data and r50 saw a write during reset: both must read 0.
    set_instr(OP_A, 3'd1, 7'd13, 7'd12, 1, 7'd10, 1, 7'd50, 1, 18'h32, 0);
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_stall: stall=%b expected 0", stall);
    end
    push_exp(OP_A, 3'd1, 7'd13, '0, '0, '0, 18'h32, 0);
    @(negedge clk);
    clr_in();
  endtask

  initial begin
    test_reset();
    test_even_bypass();
    test_both_wb();
    test_load_use();
    test_store_and_nop();
    test_back_to_back();
    test_reset_flush();
    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
